alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU instance between NUM_REQ requesters (e.g. EX stage and address generator).

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 32 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/alu_share_arbiter.sv | 105 ++++++++++
 tb/tb_alu_share_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath width and the
// operand bundle carried from the arbiter into the ALU stage.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_AND  = 4'b0111,
        ALU_OR   = 4'b0110,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0001,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    // Opcode kept as raw bits so undefined encodings pass through untouched.
    typedef struct packed {
        logic [XLEN-1:0] op_1;
        logic [XLEN-1:0] op_2;
        logic [3:0]      opcode;
    } alu_req_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; undefined opcodes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] op_1_i,
    input  logic [XLEN-1:0] op_2_i,
    input  logic [3:0]      opcode_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0] shamt;
    assign shamt = op_2_i[4:0];

    always_comb begin
        result_o = '0;
        unique case (opcode_i)
            ALU_ADD:  result_o = op_1_i + op_2_i;
            ALU_SUB:  result_o = op_1_i - op_2_i;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}},
                                  $signed(op_1_i) < $signed(op_2_i)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, op_1_i < op_2_i};
            ALU_AND:  result_o = op_1_i & op_2_i;
            ALU_OR:   result_o = op_1_i | op_2_i;
            ALU_XOR:  result_o = op_1_i ^ op_2_i;
            ALU_SLL:  result_o = op_1_i << shamt;
            ALU_SRL:  result_o = op_1_i >> shamt;
            ALU_SRA:  result_o = XLEN'($signed(op_1_i) >>> shamt);
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts just above the last winner and
// the pointer moves only when the granted request is actually taken.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_en_i,
    output logic [N-1:0] grant_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] win;
    logic [N-1:0]  hi;
    logic [N-1:0]  src;

    // Requests above the pointer win first; otherwise wrap to the bottom.
    always_comb begin
        hi = '0;
        for (int i = 0; i < N; i++) begin
            hi[i] = (i > int'(last_q)) & req_i[i];
        end
        src = (hi != '0) ? hi : req_i;
        grant_o = '0;
        win = last_q;
        for (int i = N - 1; i >= 0; i--) begin
            if (src[i]) begin
                grant_o = '0;
                grant_o[i] = 1'b1;
                win = IW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= IW'(N - 1);
        end else if (advance_en_i && (|req_i)) begin
            last_q <= win;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NUM_REQ requesters: round-robin pick into an operand
// register, ALU, then a result register tagged with the requester index.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_REQ-1:0]      req_valid_in,
    output logic [NUM_REQ-1:0]      req_ready_out,
    input  logic [32*NUM_REQ-1:0]   req_op_1_in,
    input  logic [32*NUM_REQ-1:0]   req_op_2_in,
    input  logic [4*NUM_REQ-1:0]    req_opcode_in,
    output logic                    rsp_valid_out,
    input  logic                    rsp_ready_in,
    output logic [31:0]             rsp_result_out,
    output logic [ID_W-1:0]         rsp_id_out,
    output logic                    busy_out
);

    alu_req_t        op_q;
    alu_req_t        op_d;
    logic [ID_W-1:0] op_id_q;
    logic [ID_W-1:0] op_id_d;
    logic            op_vld_q;
    logic            rsp_vld_q;
    logic [XLEN-1:0] rsp_result_q;
    logic [ID_W-1:0] rsp_id_q;

    logic [NUM_REQ-1:0] grant;
    logic [XLEN-1:0]    alu_res;
    logic               advance;
    logic               accept;
    logic               xfer;

    assign advance = op_vld_q & (~rsp_vld_q | rsp_ready_in);
    assign accept  = (~op_vld_q | advance) & ~rst_in;
    assign xfer    = accept & (|req_valid_in);

    assign req_ready_out  = grant & {NUM_REQ{accept}};
    assign rsp_valid_out  = rsp_vld_q;
    assign rsp_result_out = rsp_result_q;
    assign rsp_id_out     = rsp_id_q;
    assign busy_out       = op_vld_q | rsp_vld_q;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .req_i        (req_valid_in),
        .advance_en_i (accept),
        .grant_o      (grant)
    );

    always_comb begin
        op_d    = op_q;
        op_id_d = op_id_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op_d.op_1   = req_op_1_in[XLEN*i +: XLEN];
                op_d.op_2   = req_op_2_in[XLEN*i +: XLEN];
                op_d.opcode = req_opcode_in[4*i +: 4];
                op_id_d     = ID_W'(i);
            end
        end
    end

    alu u_alu (
        .op_1_i   (op_q.op_1),
        .op_2_i   (op_q.op_2),
        .opcode_i (op_q.opcode),
        .result_o (alu_res)
    );

    // Load and drain can coincide, keeping the pipe bubble-free.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            op_q         <= '0;
            op_id_q      <= '0;
            op_vld_q     <= 1'b0;
            rsp_vld_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
        end else begin
            if (xfer) begin
                op_q     <= op_d;
                op_id_q  <= op_id_d;
                op_vld_q <= 1'b1;
            end else if (advance) begin
                op_vld_q <= 1'b0;
            end
            if (advance) begin
                rsp_result_q <= alu_res;
                rsp_id_q     <= op_id_q;
                rsp_vld_q    <= 1'b1;
            end else if (rsp_ready_in && rsp_vld_q) begin
                rsp_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with two requesters.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld_a [2];
    logic [31:0] a_v [2];
    logic [31:0] b_v [2];
    logic [3:0]  oc_v [2];
    logic [1:0]  rdy;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] res;
    logic [0:0]  rid;
    logic        busy;

    exp_t sbq[$];
    int   grant_log[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter #(.NUM_REQ(2)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_valid_in   ({vld_a[1], vld_a[0]}),
        .req_ready_out  (rdy),
        .req_op_1_in    ({a_v[1], a_v[0]}),
        .req_op_2_in    ({b_v[1], b_v[0]}),
        .req_opcode_in  ({oc_v[1], oc_v[0]}),
        .rsp_valid_out  (rsp_valid),
        .rsp_ready_in   (rsp_ready),
        .rsp_result_out (res),
        .rsp_id_out     (rid),
        .busy_out       (busy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response must match the head of the queue.
    always @(negedge clk) begin
        #3;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %h id %0d, required none",
                         res, rid);
            end else begin : pop_blk
                exp_t e;
                e = sbq.pop_front();
                check("rsp_result", res, e.res);
                check("rsp_id", 32'(rid), 32'(e.id));
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Called just after a falling edge; returns on a falling edge.
    task automatic drive(input int r, input logic [3:0] oc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        vld_a[r] = 1'b1;
        a_v[r] = a;
        b_v[r] = b;
        oc_v[r] = oc;
        while (!got && n < 50) begin
            #1;
            got = (r == 1) ? rdy[1] : rdy[0];
            @(posedge clk);
            if (got) begin
                sbq.push_back('{e, r});
                grant_log.push_back(r);
            end
            @(negedge clk);
            n++;
        end
        vld_a[r] = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: req %0d not accepted in %0d cycles, required acceptance",
                     r, n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    logic [3:0]  t4_op [8];
    logic [31:0] t4_a [8];
    logic [31:0] t4_b [8];
    logic [31:0] t4_e [8];
    int          exp_g [4];

    initial begin
        t4_op = '{ALU_SLTU, ALU_SLT, ALU_SRA, ALU_SLL,
                  ALU_SRL, ALU_AND, ALU_SUB, 4'b1111};
        t4_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1,
                  32'h8000_0000, 32'hF0F0, 32'd3, 32'h1234};
        t4_b  = '{32'd1, 32'd1, 32'd4, 32'd31,
                  32'd31, 32'hFF00, 32'd5, 32'h5678};
        t4_e  = '{32'd0, 32'd1, 32'hF800_0000, 32'h8000_0000,
                  32'd1, 32'hF000, 32'hFFFF_FFFE, 32'd0};
        exp_g = '{1, 0, 1, 0};
        for (int i = 0; i < 2; i++) begin
            vld_a[i] = 1'b1;
            a_v[i] = '0;
            b_v[i] = '0;
            oc_v[i] = '0;
        end
        rsp_ready = 1'b1;

        // Reset state, with both requests raised
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_result", res, 32'd0);
        check("rst_id", 32'(rid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(rdy), 32'd0);
        vld_a[0] = 1'b0;
        vld_a[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 1: single ADD, two-cycle latency
        @(negedge clk);
        drive(0, ALU_ADD, 32'd5, 32'd7, 32'd12);
        #3;
        check("t1_valid_n1", 32'(rsp_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #3;
        check("t1_valid_n2", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        drain();

        // 2: both requesters contend; last winner was 0 so 1 goes first
        @(negedge clk);
        grant_log.delete();
        fork
            begin
                drive(0, ALU_SUB, 32'd10, 32'd3, 32'd7);
                drive(0, ALU_SUB, 32'd10, 32'd3, 32'd7);
            end
            begin
                drive(1, ALU_XOR, 32'hF0, 32'h0F, 32'hFF);
                drive(1, ALU_XOR, 32'hF0, 32'h0F, 32'hFF);
            end
        join
        check("t2_grant_cnt", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("t2_grant", 32'(grant_log[i]), 32'(exp_g[i]));
        end
        drain();

        // 3: output stall with two ops in flight
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(0, ALU_ADD, 32'd100, 32'd23, 32'd123);
        drive(1, ALU_OR, 32'hF0F0, 32'h0F00, 32'hFFF0);
        vld_a[0] = 1'b1;
        a_v[0] = 32'hDEAD;
        repeat (4) begin
            #1;
            check("t3_ready", 32'(rdy), 32'd0);
            check("t3_result", res, 32'd123);
            check("t3_id", 32'(rid), 32'd0);
            check("t3_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        vld_a[0] = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // 4: compare, shift and unknown-opcode corners
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(0, t4_op[i], t4_a[i], t4_b[i], t4_e[i]);
        end
        drain();

        // 5: async reset mid-stall; leaves last winner at 0 beforehand
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1, ALU_ADD, 32'd2, 32'd2, 32'd4);
        drive(0, ALU_ADD, 32'd1, 32'd1, 32'd2);
        #2;
        vld_a[0] = 1'b1;
        vld_a[1] = 1'b1;
        rst = 1'b1;
        sbq.delete();
        #1;
        check("t5_valid", 32'(rsp_valid), 32'd0);
        check("t5_result", res, 32'd0);
        check("t5_id", 32'(rid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(rdy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vld_a[0] = 1'b0;
        vld_a[1] = 1'b0;
        rsp_ready = 1'b1;
        grant_log.delete();
        fork
            drive(1, ALU_ADD, 32'h10, 32'h20, 32'h30);
            drive(0, ALU_XOR, 32'hFF, 32'h0F, 32'hF0);
        join
        check("t5_grant_cnt", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("t5_first", 32'(grant_log[0]), 32'd0);
            check("t5_second", 32'(grant_log[1]), 32'd1);
        end
        drain();

        // 6: eight back-to-back ops from one requester
        @(negedge clk);
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            drive(0, ALU_ADD, 32'(i), 32'd100, 32'(i + 100));
        end
        drain();
        check("t6_count", 32'(pop_cyc.size()), 32'd8);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            check("t6_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
        end

        repeat (3) @(negedge clk);
        check("final_queue", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
